// File: rtl/alu_result_stage_pkg.sv
// Shared definitions for the ALU result stage: status bit order, default widths, flag merge.
package alu_result_stage_pkg;

   localparam int unsigned WIDTH_DEF  = 16;
   localparam int unsigned DEST_W_DEF = 4;
   localparam int unsigned ST_W       = 4;

   // Bit positions inside statusOut / flags
   typedef enum logic [1:0] {
      ST_ZERO     = 2'd0,
      ST_CARRY    = 2'd1,
      ST_NEG      = 2'd2,
      ST_OVERFLOW = 2'd3
   } st_bit_e;

   function automatic logic [ST_W-1:0] merge_flags(input logic [ST_W-1:0] cur,
                                                   input logic [ST_W-1:0] status,
                                                   input logic [ST_W-1:0] mask);
      return (cur & ~mask) | (status & mask);
   endfunction

endpackage

// File: rtl/alu_skid_buffer.sv
// Generic 2-entry valid/ready register: main entry drives the output, skid entry absorbs one stall.
module alu_skid_buffer #(
   parameter int unsigned DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data
);

   logic              main_valid_q, main_valid_d;
   logic              skid_valid_q, skid_valid_d;
   logic [DATA_W-1:0] main_data_q, main_data_d;
   logic [DATA_W-1:0] skid_data_q, skid_data_d;
   logic              accept;
   logic              retire;

   assign accept    = in_valid & ~skid_valid_q;
   assign retire    = main_valid_q & out_ready;
   assign in_ready  = ~skid_valid_q;
   assign out_valid = main_valid_q;
   assign out_data  = main_data_q;

   always_comb begin
      main_valid_d = main_valid_q;
      skid_valid_d = skid_valid_q;
      main_data_d  = main_data_q;
      skid_data_d  = skid_data_q;
      if (!main_valid_q) begin
         if (accept) begin
            main_valid_d = 1'b1;
            main_data_d  = in_data;
         end
      end else if (retire) begin
         // Skid always drains first so order is preserved; accept is impossible while it is full
         if (skid_valid_q) begin
            main_data_d  = skid_data_q;
            skid_valid_d = 1'b0;
         end else if (accept) begin
            main_data_d  = in_data;
         end else begin
            main_valid_d = 1'b0;
         end
      end else if (accept) begin
         skid_valid_d = 1'b1;
         skid_data_d  = in_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         main_valid_q <= 1'b0;
         skid_valid_q <= 1'b0;
         main_data_q  <= '0;
         skid_data_q  <= '0;
      end else begin
         main_valid_q <= main_valid_d;
         skid_valid_q <= skid_valid_d;
         main_data_q  <= main_data_d;
         skid_data_q  <= skid_data_d;
      end
   end

endmodule

// File: rtl/alu_result_stage.sv
// Registered ALU output stage: skid-buffered writeback entries plus the architectural N/Z/C/V register,
// updated in program order as entries retire.
module alu_result_stage
   import alu_result_stage_pkg::*;
#(
   parameter int unsigned WIDTH  = WIDTH_DEF,
   parameter int unsigned DEST_W = DEST_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WIDTH-1:0]  in_result,
   input  logic [ST_W-1:0]   in_status,
   input  logic [ST_W-1:0]   in_flagMask,
   input  logic [DEST_W-1:0] in_dest,
   input  logic              in_we,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIDTH-1:0]  out_result,
   output logic [DEST_W-1:0] out_dest,
   output logic              out_we,
   output logic [ST_W-1:0]   flags,
   input  logic              flags_wr,
   input  logic [ST_W-1:0]   flags_wdata
);

   localparam int unsigned STATUS_LSB = WIDTH;
   localparam int unsigned MASK_LSB   = STATUS_LSB + ST_W;
   localparam int unsigned DEST_LSB   = MASK_LSB + ST_W;
   localparam int unsigned WE_BIT     = DEST_LSB + DEST_W;
   localparam int unsigned DATA_W     = WE_BIT + 1;

   logic [DATA_W-1:0] entry_in;
   logic [DATA_W-1:0] entry_head;
   logic [ST_W-1:0]   flags_q, flags_d;
   logic              retire;

   assign entry_in = {in_we, in_dest, in_flagMask, in_status, in_result};

   alu_skid_buffer #(
      .DATA_W (DATA_W)
   ) u_skid (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (entry_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (entry_head)
   );

   assign out_result = entry_head[WIDTH-1:0];
   assign out_dest   = entry_head[DEST_LSB +: DEST_W];
   assign out_we     = entry_head[WE_BIT];
   assign retire     = out_valid & out_ready;
   assign flags      = flags_q;

   // A direct write overrides the retiring op's flag update entirely
   always_comb begin
      flags_d = flags_q;
      if (flags_wr) begin
         flags_d = flags_wdata;
      end else if (retire) begin
         flags_d = merge_flags(flags_q, entry_head[STATUS_LSB +: ST_W], entry_head[MASK_LSB +: ST_W]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         flags_q <= '0;
      end else begin
         flags_q <= flags_d;
      end
   end

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: directed scenarios plus random traffic against a queue model.
module tb_alu_result_stage;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_result;
   logic [3:0]  in_status;
   logic [3:0]  in_flagMask;
   logic [3:0]  in_dest;
   logic        in_we;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_result;
   logic [3:0]  out_dest;
   logic        out_we;
   logic [3:0]  flags;
   logic        flags_wr;
   logic [3:0]  flags_wdata;

   alu_result_stage dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_result   (in_result),
      .in_status   (in_status),
      .in_flagMask (in_flagMask),
      .in_dest     (in_dest),
      .in_we       (in_we),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_result  (out_result),
      .out_dest    (out_dest),
      .out_we      (out_we),
      .flags       (flags),
      .flags_wr    (flags_wr),
      .flags_wdata (flags_wdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] result;
      logic [3:0]  status;
      logic [3:0]  mask;
      logic [3:0]  dest;
      logic        we;
   } ent_t;

   ent_t        mq[$];
   logic [15:0] retired[$];
   logic [3:0]  mflags;
   bit          last_acc;
   int          checks;
   int          errors;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one clock: the model holds at most two in-flight ops, accepts when not full,
   // retires the oldest when the sink is ready, and merges its flags under its mask.
   task automatic cycle();
      bit   acc;
      bit   ret;
      ent_t e;
      acc = in_valid && (mq.size() < 2);
      ret = (mq.size() > 0) && out_ready;
      e = '{result: in_result, status: in_status, mask: in_flagMask, dest: in_dest, we: in_we};
      @(posedge clk);
      if (rst) begin
         mq.delete();
         mflags = 4'b0000;
         acc = 1'b0;
      end else begin
         if (flags_wr) mflags = flags_wdata;
         else if (ret) mflags = (mflags & ~mq[0].mask) | (mq[0].status & mq[0].mask);
         if (ret) begin
            retired.push_back(mq[0].result);
            void'(mq.pop_front());
         end
         if (acc) mq.push_back(e);
      end
      last_acc = acc;
      #1;
      chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
      chk("in_ready", 32'(in_ready), 32'(mq.size() < 2));
      chk("flags", 32'(flags), 32'(mflags));
      if (mq.size() > 0) begin
         chk("out_result", 32'(out_result), 32'(mq[0].result));
         chk("out_dest", 32'(out_dest), 32'(mq[0].dest));
         chk("out_we", 32'(out_we), 32'(mq[0].we));
      end
   endtask

   task automatic set_op(input logic [15:0] r, input logic [3:0] st, input logic [3:0] m,
                         input logic [3:0] d, input logic w);
      in_valid    = 1'b1;
      in_result   = r;
      in_status   = st;
      in_flagMask = m;
      in_dest     = d;
      in_we       = w;
   endtask

   // Hold an op until accepted, bounded
   task automatic send(input logic [15:0] r, input logic [3:0] st, input logic [3:0] m);
      int n;
      set_op(r, st, m, r[3:0], r[0]);
      n = 0;
      do begin
         cycle();
         n++;
      end while (!last_acc && n < 20);
      if (!last_acc) chk("send_timeout", 32'(last_acc), 32'd1);
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      for (int i = 0; i < n; i++) cycle();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      checks      = 0;
      errors      = 0;
      mflags      = 4'b0000;
      last_acc    = 1'b0;
      rst         = 1'b1;
      out_ready   = 1'b0;
      flags_wr    = 1'b0;
      flags_wdata = 4'b0000;
      set_op(16'hDEAD, 4'hF, 4'hF, 4'h3, 1'b1);

      // Reset with in_valid held high
      cycle();
      cycle();
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_flags", 32'(flags), 32'd0);
      chk("rst_out_result", 32'(out_result), 32'd0);
      chk("rst_out_dest", 32'(out_dest), 32'd0);
      chk("rst_out_we", 32'(out_we), 32'd0);
      rst = 1'b0;
      in_valid = 1'b0;
      cycle();

      // Streaming: one op per cycle, 1-cycle latency
      retired.delete();
      out_ready = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         set_op(16'(k), 4'h0, 4'h0, 4'(k), 1'b1);
         cycle();
         chk("stream_head", 32'(out_result), 32'(k));
         chk("stream_ready", 32'(in_ready), 32'd1);
      end
      idle(2);
      chk("stream_count", 32'(retired.size()), 32'd8);
      for (int i = 0; i < 8 && i < retired.size(); i++)
         chk("stream_order", 32'(retired[i]), 32'(i + 1));

      // Backpressure: two ops fill the stage, the third waits
      retired.delete();
      out_ready = 1'b0;
      send(16'hAAAA, 4'h0, 4'h0);
      send(16'h5555, 4'h0, 4'h0);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      set_op(16'h1234, 4'h0, 4'h0, 4'h4, 1'b1);
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("bp_held_head", 32'(out_result), 32'hAAAA);
         chk("bp_held_accept", 32'(last_acc), 32'd0);
      end
      out_ready = 1'b1;
      send(16'h1234, 4'h0, 4'h0);
      idle(4);
      chk("bp_count", 32'(retired.size()), 32'd3);
      if (retired.size() == 3) begin
         chk("bp_order0", 32'(retired[0]), 32'hAAAA);
         chk("bp_order1", 32'(retired[1]), 32'h5555);
         chk("bp_order2", 32'(retired[2]), 32'h1234);
      end

      // Flag mask merge
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      send(16'h0011, 4'b1111, 4'b0101);
      cycle();
      chk("mask_a", 32'(flags), 32'b0101);
      send(16'h0022, 4'b0000, 4'b0010);
      cycle();
      chk("mask_b", 32'(flags), 32'b0101);

      // Direct write beats a same-cycle retire
      out_ready = 1'b0;
      send(16'h0033, 4'b0111, 4'b1111);
      out_ready   = 1'b1;
      flags_wr    = 1'b1;
      flags_wdata = 4'b1000;
      cycle();
      flags_wr = 1'b0;
      chk("prio_flags", 32'(flags), 32'b1000);
      chk("prio_retired", 32'(mq.size()), 32'd0);

      // Reset with both entries full
      out_ready = 1'b0;
      send(16'h0044, 4'b1111, 4'b1111);
      send(16'h0055, 4'b1111, 4'b1111);
      chk("mid_full", 32'(in_ready), 32'd0);
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      chk("mid_out_valid", 32'(out_valid), 32'd0);
      chk("mid_flags", 32'(flags), 32'd0);
      chk("mid_in_ready", 32'(in_ready), 32'd1);
      out_ready = 1'b1;
      send(16'h0BEE, 4'h0, 4'h0);
      chk("mid_after", 32'(out_result), 32'h0BEE);
      idle(2);

      // Random traffic; an unaccepted op is held stable
      for (int i = 0; i < 400; i++) begin
         if (!in_valid || last_acc)
            set_op(16'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));
         if (!last_acc && in_valid) begin
         end else begin
            in_valid = ($urandom_range(0, 3) != 0);
         end
         out_ready   = ($urandom_range(0, 3) != 0);
         flags_wr    = ($urandom_range(0, 9) == 0);
         flags_wdata = 4'($urandom);
         cycle();
      end
      flags_wr = 1'b0;
      out_ready = 1'b1;
      idle(3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
